// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC generator: picks next PC (EX correction > interrupt > stall > BTB > PC+4),
// carries predictions IF->ID->EX and flags mispredicts. Optional MISPRED_CNT_EN builds a mispredict counter.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic [31:0]      i_btb_pc,
    input  logic             i_btb_sel,
    input  logic             i_ex_ctrl,
    input  logic             i_ex_taken,
    input  logic [31:0]      i_ex_target,
    input  logic             i_irq_req,
    input  logic [31:0]      i_irq_vector,
    output logic [31:0]      o_pc_IF,
    output logic [31:0]      o_pc_EX,
    output logic             o_flush_ID,
    output logic             o_flush_EX,
    output logic             o_mispred,
    output logic             o_irq_ack,
    output logic [31:0]      o_epc,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } slot_t;

    logic [31:0] pc_q, pc_d;
    slot_t       id_q, id_d;
    slot_t       ex_q, ex_d;
    slot_t       if_slot;
    logic        mispred;
    logic        irq_take;
    logic [31:0] correct_pc;

    always_comb begin
        if_slot.valid       = 1'b1;
        if_slot.pc          = pc_q;
        if_slot.pred_taken  = i_btb_sel;
        if_slot.pred_target = i_btb_pc;

        // Target mismatch only matters when the branch was actually taken.
        mispred    = ex_q.valid & i_ex_ctrl &
                     ((i_ex_taken != ex_q.pred_taken) |
                      (i_ex_taken & (i_ex_target != ex_q.pred_target)));
        correct_pc = i_ex_taken ? i_ex_target : ex_q.pc + 32'd4;
        irq_take   = i_irq_req & ~mispred;

        pc_d = pc_q;
        id_d = id_q;
        ex_d = id_q;
        if (mispred) begin
            pc_d = correct_pc;
            id_d = '0;
            ex_d = '0;
        end else if (irq_take) begin
            pc_d = i_irq_vector;
            id_d = '0;
        end else if (i_stall) begin
            ex_d = '0;
        end else begin
            pc_d = i_btb_sel ? i_btb_pc : pc_q + 32'd4;
            id_d = if_slot;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q <= RESET_PC;
            id_q <= '0;
            ex_q <= '0;
        end else begin
            pc_q <= pc_d;
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

    assign o_pc_IF    = pc_q;
    assign o_pc_EX    = ex_q.valid ? ex_q.pc : 32'd0;
    assign o_mispred  = mispred;
    assign o_flush_EX = mispred;
    assign o_flush_ID = mispred | irq_take;
    assign o_irq_ack  = irq_take;
    assign o_epc      = pc_q;

`ifdef MISPRED_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (mispred && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_mispred_cnt = cnt_q;
`else
    assign o_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed per-cycle vector table for fetch_redirect_unit plus a mid-run asynchronous reset sequence.
module tb_fetch_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [31:0] btb_pc;
    logic        btb_sel;
    logic        ex_ctrl;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        irq_req;
    logic [31:0] irq_vector;
    logic [31:0] pc_if;
    logic [31:0] pc_ex;
    logic        flush_id;
    logic        flush_ex;
    logic        mispred;
    logic        irq_ack;
    logic [31:0] epc;
    logic [15:0] mispred_cnt;

    int checks;
    int errors;
    logic [15:0] exp_cnt;

    typedef struct {
        logic        stall;
        logic        btb_sel;
        logic [31:0] btb_pc;
        logic        ex_ctrl;
        logic        ex_taken;
        logic [31:0] ex_target;
        logic        irq;
        logic [31:0] vec;
        logic [31:0] e_pc_if;
        logic [31:0] e_pc_ex;
        logic        e_fid;
        logic        e_fex;
        logic        e_mis;
        logic        e_ack;
    } vec_t;

    vec_t tbl[$];

    fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .i_btb_pc(btb_pc), .i_btb_sel(btb_sel),
        .i_ex_ctrl(ex_ctrl), .i_ex_taken(ex_taken), .i_ex_target(ex_target),
        .i_irq_req(irq_req), .i_irq_vector(irq_vector),
        .o_pc_IF(pc_if), .o_pc_EX(pc_ex), .o_flush_ID(flush_id), .o_flush_EX(flush_ex),
        .o_mispred(mispred), .o_irq_ack(irq_ack), .o_epc(epc), .o_mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
`ifdef MISPRED_CNT_EN
        chk(name, {16'd0, mispred_cnt}, {16'd0, exp_cnt});
`else
        chk(name, {16'd0, mispred_cnt}, 32'd0);
`endif
    endtask

    task automatic v(input logic st, input logic bs, input logic [31:0] bp,
                     input logic ec, input logic et, input logic [31:0] etg,
                     input logic ir, input logic [31:0] iv,
                     input logic [31:0] e_if, input logic [31:0] e_ex,
                     input logic fid, input logic fex, input logic mis, input logic ack);
        vec_t r;
        r.stall = st; r.btb_sel = bs; r.btb_pc = bp;
        r.ex_ctrl = ec; r.ex_taken = et; r.ex_target = etg;
        r.irq = ir; r.vec = iv;
        r.e_pc_if = e_if; r.e_pc_ex = e_ex;
        r.e_fid = fid; r.e_fex = fex; r.e_mis = mis; r.e_ack = ack;
        tbl.push_back(r);
    endtask

    task automatic idle_inputs();
        stall = 0; btb_sel = 0; btb_pc = 0; ex_ctrl = 0; ex_taken = 0;
        ex_target = 0; irq_req = 0; irq_vector = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 0;
        rst_n = 0;
        idle_inputs();

        //  st bs btb_pc        ec et ex_target     ir vec       pc_IF         pc_EX         fid fex mis ack
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 0); // 0
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h4,        32'h0,        0, 0, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h8,        32'h0,        0, 0, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'hC,        32'h4,        0, 0, 0, 0);
        v(0, 1, 32'h40,       0, 0, 32'h0,        0, 32'h0,   32'h10,       32'h8,        0, 0, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h40,       32'hC,        0, 0, 0, 0); // 5
        v(0, 0, 32'h0,        1, 1, 32'h40,       0, 32'h0,   32'h44,       32'h10,       0, 0, 0, 0);
        v(0, 1, 32'h20,       0, 0, 32'h0,        0, 32'h0,   32'h48,       32'h40,       0, 0, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h20,       32'h44,       0, 0, 0, 0);
        v(0, 0, 32'h0,        1, 1, 32'h20,       0, 32'h0,   32'h24,       32'h48,       0, 0, 0, 0);
        v(0, 0, 32'h0,        1, 1, 32'h80,       0, 32'h0,   32'h28,       32'h20,       1, 1, 1, 0); // 10
        v(0, 0, 32'h0,        1, 1, 32'h999,      0, 32'h0,   32'h80,       32'h0,        0, 0, 0, 0);
        v(0, 1, 32'h30,       1, 0, 32'h0,        0, 32'h0,   32'h84,       32'h0,        0, 0, 0, 0);
        v(0, 1, 32'h100,      0, 0, 32'h0,        0, 32'h0,   32'h30,       32'h80,       0, 0, 0, 0);
        v(0, 0, 32'h0,        1, 1, 32'h30,       0, 32'h0,   32'h100,      32'h84,       0, 0, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,   32'h104,      32'h30,       1, 1, 1, 0); // 15
        v(0, 1, 32'h50,       0, 0, 32'h0,        0, 32'h0,   32'h34,       32'h0,        0, 0, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h200, 32'h50,       32'h0,        1, 0, 0, 1);
        v(0, 0, 32'h0,        1, 1, 32'h50,       0, 32'h0,   32'h200,      32'h34,       0, 0, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h204,      32'h0,        0, 0, 0, 0);
        v(0, 0, 32'h0,        1, 1, 32'h300,      1, 32'h200, 32'h208,      32'h200,      1, 1, 1, 0); // 20
        v(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h200, 32'h300,      32'h0,        1, 0, 0, 1);
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h200,      32'h0,        0, 0, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h204,      32'h0,        0, 0, 0, 0);
        v(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h208,      32'h200,      0, 0, 0, 0);
        v(1, 0, 32'h0,        1, 1, 32'h777,      0, 32'h0,   32'h208,      32'h0,        0, 0, 0, 0); // 25
        v(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h208,      32'h0,        0, 0, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h208,      32'h0,        0, 0, 0, 0);
        v(1, 0, 32'h0,        1, 1, 32'h400,      0, 32'h0,   32'h20C,      32'h204,      1, 1, 1, 0);
        v(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       0, 32'h0,   32'h400,      32'h0,        0, 0, 0, 0);
        v(0, 1, 32'h500,      0, 0, 32'h0,        0, 32'h0,   32'hFFFF_FFFC, 32'h0,       0, 0, 0, 0); // 30
        v(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0,  32'h500,      32'h400,      0, 0, 0, 0);
        v(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,   32'h504,      32'hFFFF_FFFC, 1, 1, 1, 0);
        v(0, 1, 32'h600,      0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h0,        0, 0, 0, 0);
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h600,      32'h0,        0, 0, 0, 0);
        v(0, 0, 32'h0,        1, 1, 32'h700,      0, 32'h0,   32'h604,      32'h0,        1, 1, 1, 0); // 35
        v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   32'h700,      32'h0,        0, 0, 0, 0);

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pc_if", pc_if, 32'h0);
        chk("rst_pc_ex", pc_ex, 32'h0);
        chk("rst_flags", {28'd0, flush_id, flush_ex, mispred, irq_ack}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk_cnt("rst_cnt");
        rst_n = 1;

        foreach (tbl[i]) begin
            stall = tbl[i].stall; btb_sel = tbl[i].btb_sel; btb_pc = tbl[i].btb_pc;
            ex_ctrl = tbl[i].ex_ctrl; ex_taken = tbl[i].ex_taken; ex_target = tbl[i].ex_target;
            irq_req = tbl[i].irq; irq_vector = tbl[i].vec;
            #1;
            chk($sformatf("v%0d_pc_if", i), pc_if, tbl[i].e_pc_if);
            chk($sformatf("v%0d_pc_ex", i), pc_ex, tbl[i].e_pc_ex);
            chk($sformatf("v%0d_flush_id", i), {31'd0, flush_id}, {31'd0, tbl[i].e_fid});
            chk($sformatf("v%0d_flush_ex", i), {31'd0, flush_ex}, {31'd0, tbl[i].e_fex});
            chk($sformatf("v%0d_mispred", i), {31'd0, mispred}, {31'd0, tbl[i].e_mis});
            chk($sformatf("v%0d_irq_ack", i), {31'd0, irq_ack}, {31'd0, tbl[i].e_ack});
            if (tbl[i].e_ack) chk($sformatf("v%0d_epc", i), epc, tbl[i].e_pc_if);
            chk_cnt($sformatf("v%0d_cnt", i));
            @(posedge clk);
            if (tbl[i].e_mis) exp_cnt = exp_cnt + 16'd1;
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a cycle clears state immediately.
        idle_inputs();
        #1;
        chk_cnt("pre_mid_rst_cnt");
        #1;
        rst_n = 0;
        exp_cnt = 0;
        #1;
        chk("mid_rst_pc_if", pc_if, 32'h0);
        chk("mid_rst_pc_ex", pc_ex, 32'h0);
        chk_cnt("mid_rst_cnt");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("post_rst_pc0", pc_if, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("post_rst_pc1", pc_if, 32'h4);
        chk("post_rst_pc_ex", pc_ex, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("post_rst_pc2", pc_if, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Fetch-stage PC generator that sits directly upstream of the branch predictor. It owns the IF program counter that indexes the BTB and picks the next PC from the BTB prediction, sequential PC+4, an interrupt vector, or an EX-stage correction. It carries each fetched instruction's prediction through ID to EX, detects mispredictions there, and raises pipeline flushes and the corrective redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- CNT_W, 16, width of mispredict counter (used only with MISPRED_CNT_EN)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_stall  in  1  hold IF and ID (load-use/memory stall)
- i_btb_pc  in  32  predicted next PC from branch predictor for o_pc_IF
- i_btb_sel  in  1  1 = BTB predicts taken for o_pc_IF
- i_ex_ctrl  in  1  EX holds a B-type/JAL/JALR instruction
- i_ex_taken  in  1  EX resolved outcome (taken)
- i_ex_target  in  32  EX resolved target address
- i_irq_req  in  1  level interrupt request
- i_irq_vector  in  32  interrupt handler address
- o_pc_IF  out  32  current fetch PC (drives BTB pc_IF)
- o_pc_EX  out  32  PC of instruction in EX (drives BTB pc_EX)
- o_flush_ID  out  1  squash the IF/ID register contents
- o_flush_EX  out  1  squash the ID/EX register contents
- o_mispred  out  1  EX misprediction this cycle
- o_irq_ack  out  1  one-cycle interrupt acceptance pulse
- o_epc  out  32  PC to resume at after interrupt; valid with o_irq_ack
- o_mispred_cnt  out  CNT_W  mispredictions since reset

## Operation
- Metadata shift chain IF→ID→EX, per slot: {valid, pc, pred_taken, pred_target}. IF slot: {1, o_pc_IF, i_btb_sel, i_btb_pc}.
- Mispredict in EX, combinational: m = ex.valid & i_ex_ctrl & ((i_ex_taken != ex.pred_taken) | (i_ex_taken & i_ex_target != ex.pred_target)).
- Correct PC: i_ex_taken ? i_ex_target : ex.pc + 4. Addition is 32-bit and wraps modulo 2^32.
- Next-PC priority, highest first:
  1. Mispredict: o_mispred=1, o_flush_ID=1, o_flush_EX=1. Both younger slots become invalid. PC ← correct PC.
  2. Interrupt: i_irq_req=1 and no mispredict. o_irq_ack=1, o_epc=o_pc_IF, o_flush_ID=1. PC ← i_irq_vector.
  3. Stall: PC, IF slot and ID slot hold. EX slot receives a bubble (valid=0).
  4. Taken prediction: i_btb_sel=1, PC ← i_btb_pc.
  5. Otherwise PC ← o_pc_IF + 4.
- Mispredict and interrupt both override i_stall.
- An interrupt arriving together with a mispredict stays pending and is accepted on a later cycle with no mispredict.
- Flushed or bubble slots (valid=0) never produce o_mispred or increment the counter.
- o_pc_EX = ex.pc, or 0 when ex.valid=0.

## Timing
- Reset values (asynchronous): PC=RESET_PC, all slot valid=0, pred fields 0, o_mispred_cnt=0.
- Consequently, during reset: o_flush_ID/o_flush_EX/o_mispred/o_irq_ack=0, o_epc=RESET_PC, o_pc_EX=0.
- Reset asserted mid-operation clears everything immediately. The first fetch after release is at RESET_PC.
- o_pc_IF is a register output. The BTB reads it combinationally and returns i_btb_* in the same cycle.
- EX resolution to redirected o_pc_IF: 1 edge. Mispredict penalty: 2 squashed instructions.
- o_flush_*, o_mispred, o_irq_ack and o_epc are combinational, asserted in the decision cycle only.
- A prediction fetched at cycle t is compared in EX at t+2 when there are no stalls.

## Configuration
- MISPRED_CNT_EN defined: o_mispred_cnt is a CNT_W-bit register.
  - Increments on each edge where o_mispred=1.
  - Saturates at all-ones.
  - Cleared by reset.
- MISPRED_CNT_EN undefined: the counter is not built and o_mispred_cnt is tied to 0.

## Test plan
- Reset release, no BTB hits, no stall: o_pc_IF steps 0,4,8,C on successive edges. Flushes stay 0.
- BTB hit at PC 0x10 (i_btb_sel=1, i_btb_pc=0x40), EX later resolves taken to 0x40:
  - next o_pc_IF=0x40;
  - o_mispred never asserts.
- Fetch at 0x20 predicted not-taken, EX resolves taken to 0x80:
  - o_mispred, o_flush_ID and o_flush_EX pulse for one cycle;
  - next o_pc_IF=0x80;
  - o_mispred_cnt=1 with MISPRED_CNT_EN.
- Predicted taken to 0x100, actual not-taken at ex.pc=0x30: redirect to 0x34. Also check ex.pc=0xFFFF_FFFC wraps to 0x0.
- i_irq_req with i_irq_vector=0x200 at o_pc_IF=0x50:
  - o_irq_ack=1, o_epc=0x50, o_flush_ID=1;
  - next o_pc_IF=0x200.
  - Repeat with i_irq_req coinciding with a mispredict: redirect wins, ack follows one cycle later.
- i_stall held 3 cycles: o_pc_IF is constant and EX sees bubbles with no mispredict. A mispredict arriving during the stall still redirects, and o_pc_IF follows it.
